uart_rx: RTL and testbench

- Asynchronous serial receiver: 8 data bits, no parity, 1 stop bit, LSB first.
- Oversamples the line with the system clock through a baud counter derived from parameters, so it needs no external baud tick.
- Presents each received byte with a one-cycle strobe.
- Sits between the board's serial RX pin and the command-decode logic; it is the receive-side counterpart of the existing transmitter on the same link.

---
 rtl/uart_rx.sv | 114 +++++++++++
 tb/tb_uart_rx.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver with an internal baud counter.
// The line is sampled at mid-bit, with no re-synchronisation inside a frame.
// It returns to IDLE at mid-stop-bit, so a start bit that follows the stop
// bit with no gap is still caught.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge
// START | timing to mid start bit; a high sample here is a glitch
// DATA  | sampling 8 data bits, one every BIT_CNT cycles, LSB first
// STOP  | sampling the stop bit; high = good frame, low = framing error
`timescale 1ns/1ps
module uart_rx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       busy
);
    localparam int BIT_CNT = CLK_FREQ / BAUD;
    localparam int HALF    = BIT_CNT / 2;
    localparam int CW      = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BIT_CNT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic          rx_m, rx_s, rx_d;
    logic          fall;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          half_hit, full_hit, sample;

    assign fall     = rx_d & ~rx_s;
    assign half_hit = (cnt == HALF_M1);
    assign full_hit = (cnt == FULL_M1);
    assign sample   = ((state == START) && half_hit) ||
                      (((state == DATA) || (state == STOP)) && full_hit);

    // Two-flop synchronizer plus one delay flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (fall) state_nxt = START;
            START: if (half_hit) state_nxt = rx_s ? IDLE : DATA;
            DATA:  if (full_hit && (bit_idx == 3'd7)) state_nxt = STOP;
            STOP:  if (full_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state != IDLE);
    end

    // Baud counter, bit index, shift register and registered result/pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            rx_data   <= 8'h00;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            if ((state == IDLE) || (state_nxt != state) || sample)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if ((state == START) && half_hit)
                bit_idx <= 3'd0;
            if ((state == DATA) && full_hit) begin
                shift[bit_idx] <= rx_s;
                bit_idx        <= bit_idx + 3'd1;
            end
            if ((state == STOP) && full_hit) begin
                if (rx_s) begin
                    rx_data <= shift;
                    rx_done <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed cases plus random frames, checked by a
// scoreboard monitor against expectations pushed by the stimulus driver.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int CLK_FREQ = 16000;
    localparam int BAUD     = 1000;
    localparam int BITW     = 16;
    localparam int HALFW    = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done, frame_err, busy;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         busy_q[$];
    logic [7:0] last_good = 8'h00;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx),
        .rx_data(rx_data), .rx_done(rx_done), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: a good stop bit yields rx_done with the byte; a low stop bit yields
    // frame_err with rx_data still showing the last good byte. Every frame keeps
    // busy high from START entry to mid-stop: HALF + 9 bit times.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        if (stop) begin
            exp_q.push_back({1'b0, d});
            last_good = d;
        end else begin
            exp_q.push_back({1'b1, last_good});
        end
        busy_q.push_back(HALFW + 9 * BITW);
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            cyc(BITW);
        end
        rx = 1'b1;
    endtask

    task automatic glitch();
        busy_q.push_back(HALFW);
        rx = 1'b0;
        cyc(4);
        rx = 1'b1;
        cyc(30);
    endtask

    // Scoreboard monitor: pops an expectation on each pulse and on each busy run.
    initial begin
        exp_t e;
        int   run;
        run = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run = 0;
            end else begin
                if (rx_done || frame_err) begin
                    check("pulse_exclusive", 32'(rx_done & frame_err), 32'd0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_pulse", 32'({rx_done, frame_err}), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_err", 32'(frame_err), 32'(e.is_err));
                        check("rx_done", 32'(rx_done), 32'(!e.is_err));
                        check("rx_data", 32'(rx_data), 32'(e.data));
                    end
                end
                if (busy) begin
                    run++;
                end else if (run > 0) begin
                    if (busy_q.size() == 0) check("unexpected_busy", 32'(run), 32'd0);
                    else                    check("busy_len", 32'(run), 32'(busy_q.pop_front()));
                    run = 0;
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int         r;
        int         gap;

        rst_n = 1'b0;
        rx    = 1'b1;
        cyc(3);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_done", 32'(rx_done), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        cyc(5);

        send_frame(8'hA5, 1'b1);
        cyc(10);
        check("hold_a5", 32'(rx_data), 32'h0A5);

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        cyc(10);

        glitch();
        check("glitch_hold", 32'(rx_data), 32'(last_good));

        send_frame(8'h11, 1'b1);
        send_frame(8'h3C, 1'b0);
        cyc(10);
        check("ferr_hold", 32'(rx_data), 32'h011);
        send_frame(8'h42, 1'b1);
        cyc(10);

        d  = 8'h96;
        rx = 1'b0;
        cyc(BITW);
        for (int k = 0; k < 4; k++) begin
            rx = d[k];
            cyc(BITW);
        end
        rx = d[4];
        cyc(HALFW);
        rst_n = 1'b0;
        rx    = 1'b1;
        cyc(1);
        check("midrst_rx_data", 32'(rx_data), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        cyc(5);
        check("midrst_rx_done", 32'(rx_done), 32'd0);
        check("midrst_frame_err", 32'(frame_err), 32'd0);
        check("midrst_busy2", 32'(busy), 32'd0);
        last_good = 8'h00;
        rst_n = 1'b1;
        cyc(40);
        send_frame(8'h5A, 1'b1);
        cyc(10);
        check("post_rst_5a", 32'(rx_data), 32'h05A);

        for (int n = 0; n < 25; n++) begin
            d = 8'($urandom_range(0, 255));
            r = int'($urandom_range(0, 9));
            if (r == 0) glitch();
            send_frame(d, (r > 1));
            gap = (r > 1) ? int'($urandom_range(0, 12)) : int'($urandom_range(4, 12));
            cyc(gap);
        end

        cyc(40);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("busy_q_drained", 32'(busy_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
